// File: rtl/hamming_pkg.sv
// Shared Hamming(38,32) definitions: widths, position helpers and parity masks.
// Used by both the encoder and the matching corrector.
package hamming_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned PAR_W  = 6;
   localparam int unsigned CODE_W = DATA_W + PAR_W;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned POS_W  = 6;
   localparam int unsigned PIDX_W = $clog2(PAR_W);

   // True for 1-based codeword positions that hold a parity bit (powers of two).
   function automatic logic is_parity_pos(input int unsigned p);
      return (p != 32'd0) && ((p & (p - 32'd1)) == 32'd0);
   endfunction

   // 1-based codeword position of data bit i; data fills non-parity slots in order.
   function automatic int unsigned data_to_pos(input int unsigned i);
      int unsigned n   = 0;
      int unsigned pos = 0;
      for (int unsigned p = 1; p <= CODE_W; p++) begin
         if (!is_parity_pos(p)) begin
            if (n == i) pos = p;
            n++;
         end
      end
      return pos;
   endfunction

   // Data-bearing positions covered by parity bit k.
   function automatic logic [CODE_W-1:0] par_mask(input int unsigned k);
      logic [CODE_W-1:0] m = '0;
      for (int unsigned p = 1; p <= CODE_W; p++) begin
         if (!is_parity_pos(p) && (((p >> k) & 32'd1) != 32'd0))
            m = m | (CODE_W'(1) << (p - 32'd1));
      end
      return m;
   endfunction

   function automatic logic [PAR_W-1:0][CODE_W-1:0] build_par_masks();
      logic [PAR_W-1:0][CODE_W-1:0] r;
      for (int unsigned k = 0; k < PAR_W; k++) r[PIDX_W'(k)] = par_mask(k);
      return r;
   endfunction

   localparam logic [PAR_W-1:0][CODE_W-1:0] PAR_MASK = build_par_masks();

endpackage

// File: rtl/hamming_encoder_pipe_if.sv
// Valid/ready stream bundle: data words in, codewords out, plus injection controls.
interface hamming_encoder_pipe_if;
   import hamming_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   in_data;
   logic                inj_en;
   logic [POS_W-1:0]    inj_pos;
   logic                out_valid;
   logic                out_ready;
   logic [CODE_W-1:0]   out_code;
   logic                out_injected;

   // Producer of data words / consumer of codewords.
   modport master (
      output in_valid, in_data, inj_en, inj_pos, out_ready,
      input  in_ready, out_valid, out_code, out_injected
   );

   // The encoder itself.
   modport slave (
      input  in_valid, in_data, inj_en, inj_pos, out_ready,
      output in_ready, out_valid, out_code, out_injected
   );

endinterface

// File: rtl/hamming_encode_comb.sv
// Purely combinational data -> codeword scatter and even-parity generation.
module hamming_encode_comb
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] i_data,
   output logic [CODE_W-1:0] o_code
);

   logic [CODE_W-1:0] w_scat;

   // Place data bits at their non-parity positions; parity slots start at zero.
   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
      localparam int unsigned P = data_to_pos(gi);
      assign w_scat[P-1] = i_data[gi];
   end

   for (genvar gk = 0; gk < PAR_W; gk++) begin : g_pzero
      assign w_scat[(2**gk)-1] = 1'b0;
   end

   // Parity slots take the XOR of their covered data positions.
   for (genvar gp = 1; gp <= CODE_W; gp++) begin : g_pos
      if (is_parity_pos(gp)) begin : g_p
         localparam int unsigned K = $clog2(gp);
         assign o_code[gp-1] = ^(w_scat & PAR_MASK[K]);
      end else begin : g_d
         assign o_code[gp-1] = w_scat[gp-1];
      end
   end

endmodule

// File: rtl/hamming_encoder_pipe.sv
// Two-stage elastic Hamming(38,32) encoder with optional single-bit error injection.
module hamming_encoder_pipe
   import hamming_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   hamming_encoder_pipe_if.slave  bus,
   output logic [CNT_W-1:0]       enc_count
);

   logic                r_s1_valid;
   logic [DATA_W-1:0]   r_s1_data;
   logic                r_s1_inj_en;
   logic [POS_W-1:0]    r_s1_inj_pos;
   logic                r_out_valid;
   logic [CODE_W-1:0]   r_out_code;
   logic                r_out_injected;
   logic [CNT_W-1:0]    r_enc_count;

   logic                w_s2_ready;
   logic                w_s1_ready;
   logic                w_inj_hit;
   logic [CODE_W-1:0]   w_code;
   logic [CODE_W-1:0]   w_flip;

   assign w_s2_ready = !r_out_valid || bus.out_ready;
   assign w_s1_ready = !r_s1_valid || w_s2_ready;

   // Out-of-range positions (0 or beyond the codeword) silently disable the flip.
   assign w_inj_hit = r_s1_inj_en && (r_s1_inj_pos != '0) && (r_s1_inj_pos <= POS_W'(CODE_W));
   assign w_flip    = w_inj_hit ? (CODE_W'(1) << (r_s1_inj_pos - POS_W'(1))) : '0;

   hamming_encode_comb u_encode (
      .i_data (r_s1_data),
      .o_code (w_code)
   );

   // Stage 1: capture the accepted beat; empties when it moves on with nothing behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid   <= 1'b0;
         r_s1_data    <= '0;
         r_s1_inj_en  <= 1'b0;
         r_s1_inj_pos <= '0;
      end else if (w_s1_ready) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_data    <= bus.in_data;
            r_s1_inj_en  <= bus.inj_en;
            r_s1_inj_pos <= bus.inj_pos;
         end
      end
   end

   // Stage 2: register the (optionally corrupted) codeword; held while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid    <= 1'b0;
         r_out_code     <= '0;
         r_out_injected <= 1'b0;
      end else if (w_s2_ready) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_code     <= w_code ^ w_flip;
            r_out_injected <= w_inj_hit;
         end
      end
   end

   // Count output handshakes, wrapping naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enc_count <= '0;
      end else if (r_out_valid && bus.out_ready) begin
         r_enc_count <= r_enc_count + CNT_W'(1);
      end
   end

   assign bus.in_ready     = w_s1_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.out_code     = r_out_code;
   assign bus.out_injected = r_out_injected;
   assign enc_count        = r_enc_count;

endmodule

// File: tb/tb_hamming_encoder_pipe.sv
// Self-checking bench for hamming_encoder_pipe: directed vector table plus stream,
// backpressure, mid-stream reset and counter-wrap sequences.
module tb_hamming_encoder_pipe;
   import hamming_pkg::*;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [CNT_W-1:0] enc_count;

   hamming_encoder_pipe_if bus ();

   hamming_encoder_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .enc_count (enc_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        inj_en;
      logic [5:0]  inj_pos;
      logic [37:0] exp_code;
      logic        exp_inj;
      logic [37:0] exp_clean;
   } vec_t;

   localparam int NV = 12;
   vec_t vt [NV];

   int n_chk  = 0;
   int n_fail = 0;
   int stalls = 0;
   logic [31:0] exp_q [$];
   logic        mon_en = 1'b0;
   logic        rnd_rdy = 1'b0;
   logic        held_v = 1'b0;
   logic [38:0] held;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference corrector: XOR of set positions.
   function automatic logic [5:0] syndrome(input logic [37:0] c);
      logic [5:0]  s = '0;
      logic [37:0] t;
      for (int p = 1; p <= 38; p++) begin
         t = c >> (p - 1);
         if (t[0]) s = s ^ 6'(p);
      end
      return s;
   endfunction

   function automatic logic [31:0] extract(input logic [37:0] c);
      logic [31:0] d = '0;
      logic [37:0] t;
      int          n = 0;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            t = c >> (p - 1);
            d = d | (32'(t[0]) << n);
            n++;
         end
      end
      return d;
   endfunction

   // Output monitor: ordering, clean-codeword checks and hold-while-stalled.
   always begin
      @(negedge clk);
      if (mon_en) begin
         if (held_v && bus.out_valid)
            chk("hold", 64'({bus.out_injected, bus.out_code}), 64'(held));
         held_v = bus.out_valid && !bus.out_ready;
         held   = {bus.out_injected, bus.out_code};
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 64'(1), 64'(0));
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               chk("order_data", 64'(extract(bus.out_code)), 64'(e));
               chk("syndrome", 64'(syndrome(bus.out_code)), 64'(0));
               chk("injected", 64'(bus.out_injected), 64'(0));
            end
         end
      end else begin
         held_v = 1'b0;
      end
   end

   // Random out_ready toggling when enabled.
   always begin
      @(posedge clk);
      #1;
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
   end

   task automatic apply_vec(input vec_t v, input int idx);
      logic [37:0] code;
      logic [5:0]  syn;
      bus.in_valid = 1'b1;
      bus.in_data  = v.data;
      bus.inj_en   = v.inj_en;
      bus.inj_pos  = v.inj_pos;
      chk($sformatf("v%0d_in_ready", idx), 64'(bus.in_ready), 64'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.inj_en   = 1'b0;
      chk($sformatf("v%0d_lat_early", idx), 64'(bus.out_valid), 64'(0));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", idx), 64'(bus.out_valid), 64'(1));
      chk($sformatf("v%0d_code", idx), 64'(bus.out_code), 64'(v.exp_code));
      chk($sformatf("v%0d_inj", idx), 64'(bus.out_injected), 64'(v.exp_inj));
      code = bus.out_code;
      syn  = syndrome(code);
      chk($sformatf("v%0d_syn", idx), 64'(syn), 64'(v.exp_inj ? v.inj_pos : 6'd0));
      if (syn != 6'd0)
         chk($sformatf("v%0d_corrected", idx), 64'(code ^ (38'd1 << (syn - 6'd1))), 64'(v.exp_clean));
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [31:0] d);
      logic a;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.inj_en   = 1'b0;
      bus.inj_pos  = '0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         a = bus.in_ready;
         if (a) exp_q.push_back(d);
         else stalls++;
         @(posedge clk); #1;
         if (a) return;
      end
      chk("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain(input string nm);
      int c = 0;
      while (exp_q.size() != 0 && c < 3000) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk(nm, 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      logic [CNT_W-1:0] base;
      int               acc;
      int               total;
      int               cyc;
      logic             a;

      vt[0]  = '{32'h0000_0000, 1'b0, 6'd0,  38'h00_0000_0000, 1'b0, 38'h00_0000_0000};
      vt[1]  = '{32'h0000_0001, 1'b0, 6'd0,  38'h00_0000_0007, 1'b0, 38'h00_0000_0007};
      vt[2]  = '{32'h8000_0000, 1'b0, 6'd0,  38'h20_8000_000A, 1'b0, 38'h20_8000_000A};
      vt[3]  = '{32'h0000_0002, 1'b0, 6'd0,  38'h00_0000_0019, 1'b0, 38'h00_0000_0019};
      vt[4]  = '{32'h0000_0001, 1'b1, 6'd5,  38'h00_0000_0017, 1'b1, 38'h00_0000_0007};
      vt[5]  = '{32'h0000_0001, 1'b1, 6'd0,  38'h00_0000_0007, 1'b0, 38'h00_0000_0007};
      vt[6]  = '{32'h0000_0001, 1'b1, 6'd39, 38'h00_0000_0007, 1'b0, 38'h00_0000_0007};
      vt[7]  = '{32'h0000_0001, 1'b0, 6'd5,  38'h00_0000_0007, 1'b0, 38'h00_0000_0007};
      vt[8]  = '{32'h0000_0001, 1'b1, 6'd38, 38'h20_0000_0007, 1'b1, 38'h00_0000_0007};
      vt[9]  = '{32'h0000_0000, 1'b1, 6'd1,  38'h00_0000_0001, 1'b1, 38'h00_0000_0000};
      vt[10] = '{32'h0000_0001, 1'b1, 6'd63, 38'h00_0000_0007, 1'b0, 38'h00_0000_0007};
      vt[11] = '{32'hFFFF_FFFF, 1'b0, 6'd0,  38'h3F_7FFF_FFF4, 1'b0, 38'h3F_7FFF_FFF4};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.inj_en    = 1'b0;
      bus.inj_pos   = '0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_code", 64'(bus.out_code), 64'(0));
      chk("rst_out_injected", 64'(bus.out_injected), 64'(0));
      chk("rst_enc_count", 64'(enc_count), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vector table
      bus.out_ready = 1'b1;
      for (int i = 0; i < NV; i++) apply_vec(vt[i], i);
      chk("table_count", 64'(enc_count), 64'(NV));

      // Full-rate stream
      mon_en = 1'b1;
      base   = enc_count;
      stalls = 0;
      for (int i = 0; i < 1000; i++) send($urandom);
      bus.in_valid = 1'b0;
      drain("stream_drain");
      chk("stream_count", 64'(enc_count), 64'(16'(base + 16'd1000)));
      chk("stream_no_stall", 64'(stalls), 64'(0));

      // Random out_ready
      base    = enc_count;
      rnd_rdy = 1'b1;
      for (int i = 0; i < 300; i++) send($urandom);
      bus.in_valid = 1'b0;
      drain("rnd_drain");
      rnd_rdy = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("rnd_count", 64'(enc_count), 64'(16'(base + 16'd300)));

      // Backpressure: exactly two beats buffered, then simultaneous in/out
      base = enc_count;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         bus.in_data = 32'hA000 + 32'(acc);
         @(negedge clk);
         a = bus.in_ready;
         if (a) begin
            exp_q.push_back(bus.in_data);
            acc++;
         end
         @(posedge clk); #1;
      end
      chk("bp_accepts", 64'(acc), 64'(2));
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
      chk("bp_count_frozen", 64'(enc_count), 64'(base));
      bus.out_ready = 1'b1;
      #1;
      chk("bp_simul_ready", 64'(bus.in_ready), 64'(1));
      total = acc;
      for (int c = 0; c < 4; c++) begin
         bus.in_data = 32'hA000 + 32'(total);
         @(negedge clk);
         a = bus.in_ready;
         if (a) begin
            exp_q.push_back(bus.in_data);
            total++;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      drain("bp_drain");
      chk("bp_total", 64'(total), 64'(6));
      chk("bp_count", 64'(enc_count), 64'(16'(base + 16'd6)));

      // Reset with both stages full
      mon_en = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h5;
      repeat (3) @(posedge clk);
      #1;
      chk("mrst_full", 64'(bus.in_ready), 64'(0));
      chk("mrst_valid_before", 64'(bus.out_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("mrst_out_code", 64'(bus.out_code), 64'(0));
      chk("mrst_out_injected", 64'(bus.out_injected), 64'(0));
      chk("mrst_enc_count", 64'(enc_count), 64'(0));
      bus.in_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("mrst_empty", 64'(bus.out_valid), 64'(0));
      apply_vec(vt[1], 100);
      chk("mrst_count", 64'(enc_count), 64'(1));

      // Counter wrap
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3;
      cyc = 0;
      while (enc_count != 16'hFFFF && cyc < 70000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("wrap_reach_max", 64'(enc_count), 64'(16'hFFFF));
      chk("wrap_valid", 64'(bus.out_valid), 64'(1));
      @(posedge clk); #1;
      chk("wrap_zero", 64'(enc_count), 64'(0));
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hamming_encoder_pipe.md
Name: hamming_encoder_pipe

Overview:
- Hamming single-error-correcting encoder, and the write-side counterpart of the 38-bit error-correction block.
- Takes 32-bit data words over a valid/ready stream and emits 38-bit codewords with 6 parity bits.
- Codeword layout is bit-compatible with the corrector, so encoder output fed to the corrector yields a zero syndrome.
- Two-stage elastic pipeline with full backpressure.
- Includes a single-bit error-injection path so the corrector can be exercised in-system.

Parameters:
DATA_W, 32, data word width
PAR_W, 6, parity bit count; must satisfy 2**PAR_W >= DATA_W+PAR_W+1
CODE_W, DATA_W+PAR_W (38), codeword width; derived, not overridden
CNT_W, 16, width of encoded-word counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  encoder can accept input beat
in_data  input  DATA_W  data word to encode
inj_en  input  1  flip one codeword bit for this beat
inj_pos  input  6  1-based codeword position to flip (1..CODE_W)
out_valid  output  1  codeword valid
out_ready  input  1  downstream accepts codeword
out_code  output  CODE_W  encoded (optionally corrupted) codeword
out_injected  output  1  a bit was actually flipped in this codeword
enc_count  output  CNT_W  count of output handshakes, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_code=0, out_injected=0, enc_count=0; internal stage valids=0, stage data=0.
- Handshakes:
  - Input handshake occurs when in_valid && in_ready.
  - Output handshake occurs when out_valid && out_ready.
  - out_code and out_injected are held stable while out_valid && !out_ready.
- Layout uses 1-based positions p = 1..38, stored at bit p-1.
  - Parity bits sit at p = 1, 2, 4, 8, 16, 32 (bit indices 0, 1, 3, 7, 15, 31).
  - Data bits fill the remaining positions in ascending order: in_data[0] at p=3, [1] at p=5, [2] at 6, [3] at 7, [4] at 9, …, [31] at p=38.
- Parity: parity bit k = XOR of all data-bearing positions p with bit k of p set. This makes the XOR over all positions with bit k set equal to 0 (even), so the corrector's syndrome is 0 for a clean codeword.
- Stage 1 (S1): on input handshake, register in_data, inj_en, inj_pos; s1_valid <= 1.
- Stage 2 (S2): register the scattered codeword with parity. If the S1 inj_en=1 and 1 <= inj_pos <= CODE_W, XOR bit inj_pos-1 and set out_injected=1. Otherwise (including inj_pos=0 or inj_pos > 38) there is no flip and out_injected=0.
- Elastic control:
  - s2_ready = !out_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready, combinational from registered state and out_ready; no combinational path from in_valid.
  - S1 advances into S2 when s1_valid && s2_ready.
  - out_valid clears on output handshake when S1 holds no beat.
- Latency and throughput: latency is 2 cycles from input handshake to out_valid, with no stalls. Throughput is 1 word/cycle with out_ready held high.
- Backpressure: with out_ready=0, at most 2 beats are buffered. in_ready falls once both stages are full. No beat is dropped or duplicated.
- Simultaneous events: an input handshake and an output handshake in the same cycle with both stages full are legal; the pipeline shifts.
- enc_count: +1 on each output handshake; wraps from 2**CNT_W-1 to 0.
- Reset mid-operation: all in-flight beats are discarded and outputs return to reset values immediately (asynchronous assertion). Release is synchronous to clk by design.

Decomposition:
- Shared package hamming_pkg holds:
  - DATA_W, PAR_W, CODE_W constants.
  - Function is_parity_pos(p).
  - Function data_to_pos(i), returning the codeword position of data bit i.
  - Parity-mask constants per k.
  These are reused by the corrector.
- One sub-module, hamming_encode_comb (data -> 38-bit codeword, purely combinational), instantiated in S2. The pipeline and injection logic live in the top.

Test Plan:
- Clean codewords: in_data 32'h0 -> out_code 38'h0; in_data 32'h1 -> 38'h7; in_data 32'h8000_0000 -> 38'h20_8000_000A; each appears 2 cycles after accept.
- Stream with out_ready=1: 1000 random words, each out_code passed through the corrector returns unchanged; enc_count=1000.
- Backpressure: out_ready=0 with in_valid held -> exactly 2 accepts, then in_ready=0. Random out_ready toggling -> output order matches input order, no loss.
- Injection:
  - in_data 32'h1, inj_en=1, inj_pos=5 -> out_code 38'h17, out_injected=1; the corrector restores 38'h7.
  - inj_pos=0 or inj_pos=39 -> out_code 38'h7, out_injected=0.
- Counter wrap: enc_count preloaded via 65535 handshakes; the next handshake -> enc_count=0.
- Reset mid-stream: rst_n asserted with both stages full -> out_valid=0, out_code=0, enc_count=0 immediately. After release, the first new word emerges 2 cycles after accept.
